// File: rtl/reg_file_rv32i.sv
// RV32I integer register file: x1..x31 storage with x0 hardwired to zero,
// two combinational read ports with optional write-to-read forwarding and a debug port.
module reg_file_rv32i #(
  parameter int unsigned n      = 32,
  parameter int unsigned a      = 5,
  parameter int unsigned BYPASS = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         reg_write,
  input  logic [a-1:0] rd_addr,
  input  logic [n-1:0] rd_data,
  input  logic [a-1:0] rs1_addr,
  input  logic [a-1:0] rs2_addr,
  output logic [n-1:0] rs1_data,
  output logic [n-1:0] rs2_data,
  input  logic [a-1:0] dbg_addr,
  output logic [n-1:0] dbg_data
);

  localparam int unsigned NREG = 1 << a;

  logic [n-1:0] regs [1:NREG-1];
  logic         wr_en;
  logic         fwd1;
  logic         fwd2;

  assign wr_en = reg_write && (rd_addr != '0);

  // Writeback; reset clears every register and discards the same-cycle write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[rd_addr] <= rd_data;
    end
  end

  assign fwd1 = (BYPASS != 0) && wr_en && (rd_addr == rs1_addr);
  assign fwd2 = (BYPASS != 0) && wr_en && (rd_addr == rs2_addr);

  // Source 1 read: reset, then x0, then forwarding, then storage
  always_comb begin
    rs1_data = '0;
    if (rst || rs1_addr == '0) begin
      rs1_data = '0;
    end else if (fwd1) begin
      rs1_data = rd_data;
    end else begin
      rs1_data = regs[rs1_addr];
    end
  end

  // Source 2 read, independent of source 1
  always_comb begin
    rs2_data = '0;
    if (rst || rs2_addr == '0) begin
      rs2_data = '0;
    end else if (fwd2) begin
      rs2_data = rd_data;
    end else begin
      rs2_data = regs[rs2_addr];
    end
  end

  // Debug read shows stored state only: no forwarding, no reset gating
  always_comb begin
    dbg_data = '0;
    if (dbg_addr != '0) begin
      dbg_data = regs[dbg_addr];
    end
  end

endmodule

// File: tb/tb_reg_file_rv32i.sv
// Directed bench for reg_file_rv32i; a forwarding and a non-forwarding instance share stimulus.
module tb_reg_file_rv32i;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  dbg_addr;
  logic [31:0] rs1_b, rs2_b, dbg_b;
  logic [31:0] rs1_n, rs2_n, dbg_n;
  logic [32:0] sum;
  logic [31:0] exp_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_rv32i #(.n(32), .a(5), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .reg_write(reg_write), .rd_addr(rd_addr), .rd_data(rd_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_b), .rs2_data(rs2_b),
    .dbg_addr(dbg_addr), .dbg_data(dbg_b)
  );

  reg_file_rv32i #(.n(32), .a(5), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .reg_write(reg_write), .rd_addr(rd_addr), .rd_data(rd_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_n), .rs2_data(rs2_n),
    .dbg_addr(dbg_addr), .dbg_data(dbg_n)
  );

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; reg_write = 1'b0; rd_addr = '0; rd_data = '0;
    rs1_addr = 5'd1; rs2_addr = 5'd2; dbg_addr = '0;
    #1;
    chk("rst_rs1_b", {1'b0, rs1_b}, 33'h0);
    chk("rst_rs2_n", {1'b0, rs2_n}, 33'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      chk("post_rst_dbg_b", {1'b0, dbg_b}, 33'h0);
      chk("post_rst_dbg_n", {1'b0, dbg_n}, 33'h0);
    end

    // Writes to x0 are dropped and never forwarded
    reg_write = 1'b1; rd_addr = 5'd0; rd_data = 32'hDEADBEEF; rs1_addr = 5'd0; dbg_addr = 5'd0;
    #1;
    chk("x0_same_cycle_b", {1'b0, rs1_b}, 33'h0);
    chk("x0_same_cycle_n", {1'b0, rs1_n}, 33'h0);
    tick();
    reg_write = 1'b0;
    #1;
    chk("x0_after_edge", {1'b0, rs1_b}, 33'h0);
    chk("x0_dbg", {1'b0, dbg_b}, 33'h0);

    // Basic write/read and the ADD the ALU would see
    reg_write = 1'b1; rd_addr = 5'd5; rd_data = 32'hFFFFFFFF;
    tick();
    rd_addr = 5'd6; rd_data = 32'h00000001;
    tick();
    reg_write = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd6;
    #1;
    chk("x5_rs1_b", {1'b0, rs1_b}, 33'h0FFFFFFFF);
    chk("x6_rs2_b", {1'b0, rs2_b}, 33'h000000001);
    chk("x5_rs1_n", {1'b0, rs1_n}, 33'h0FFFFFFFF);
    chk("x6_rs2_n", {1'b0, rs2_n}, 33'h000000001);
    sum = {1'b0, rs1_b} + {1'b0, rs2_b};
    chk("alu_add", sum, 33'h100000000);

    // Forwarding
    reg_write = 1'b1; rd_addr = 5'd7; rd_data = 32'h11111111;
    tick();
    rd_data = 32'h22222222; rs1_addr = 5'd7; rs2_addr = 5'd7; dbg_addr = 5'd7;
    #1;
    chk("byp_rs1", {1'b0, rs1_b}, 33'h022222222);
    chk("byp_rs2", {1'b0, rs2_b}, 33'h022222222);
    chk("nobyp_rs1", {1'b0, rs1_n}, 33'h011111111);
    chk("nobyp_rs2", {1'b0, rs2_n}, 33'h011111111);
    chk("byp_dbg_pre", {1'b0, dbg_b}, 33'h011111111);
    tick();
    reg_write = 1'b0;
    #1;
    chk("byp_dbg_post", {1'b0, dbg_b}, 33'h022222222);
    chk("nobyp_rs1_post", {1'b0, rs1_n}, 33'h022222222);
    chk("byp_rs2_post", {1'b0, rs2_b}, 33'h022222222);

    // Forwarding on one port only
    reg_write = 1'b1; rd_addr = 5'd5; rd_data = 32'h0BADF00D; rs1_addr = 5'd5; rs2_addr = 5'd6;
    #1;
    chk("byp_only_rs1", {1'b0, rs1_b}, 33'h00BADF00D);
    chk("byp_not_rs2", {1'b0, rs2_b}, 33'h000000001);
    tick();

    // Reset beats a pending write
    rd_addr = 5'd3; rd_data = 32'h00000033;
    tick();
    rst = 1'b1; rd_data = 32'hABCD0000; rs1_addr = 5'd3; rs2_addr = 5'd3; dbg_addr = 5'd3;
    #1;
    chk("rst_rs1_byp", {1'b0, rs1_b}, 33'h0);
    chk("rst_rs2_nobyp", {1'b0, rs2_n}, 33'h0);
    chk("rst_dbg_pre", {1'b0, dbg_b}, 33'h000000033);
    tick();
    rst = 1'b0; reg_write = 1'b0;
    #1;
    chk("rst_x3_dbg", {1'b0, dbg_b}, 33'h0);
    chk("rst_x3_rs1", {1'b0, rs1_n}, 33'h0);
    dbg_addr = 5'd5;
    #1;
    chk("rst_x5_dbg", {1'b0, dbg_n}, 33'h0);

    // Write disable holds x9
    reg_write = 1'b0; rd_addr = 5'd9; rd_data = 32'h5; rs1_addr = 5'd9; dbg_addr = 5'd9;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("wdis_rs1_b", {1'b0, rs1_b}, 33'h0);
      tick();
    end
    chk("wdis_dbg", {1'b0, dbg_b}, 33'h0);

    // Back-to-back writes to the same register: last edge wins
    reg_write = 1'b1; rd_addr = 5'd10; rd_data = 32'h0000AAAA;
    tick();
    rd_data = 32'h0000BBBB;
    tick();
    reg_write = 1'b0; dbg_addr = 5'd10;
    #1;
    chk("b2b_dbg", {1'b0, dbg_n}, 33'h00000BBBB);

    // Full sweep
    reg_write = 1'b1;
    for (int i = 1; i < 32; i++) begin
      rd_addr = 5'(i);
      rd_data = 32'(i) * 32'h01010101;
      tick();
    end
    reg_write = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      dbg_addr = 5'(i);
      #1;
      exp_v = 32'(i) * 32'h01010101;
      chk("sweep_rs1_b", {1'b0, rs1_b}, {1'b0, exp_v});
      chk("sweep_rs1_n", {1'b0, rs1_n}, {1'b0, exp_v});
      chk("sweep_dbg", {1'b0, dbg_b}, {1'b0, exp_v});
      exp_v = 32'(31 - i) * 32'h01010101;
      chk("sweep_rs2_b", {1'b0, rs2_b}, {1'b0, exp_v});
      chk("sweep_rs2_n", {1'b0, rs2_n}, {1'b0, exp_v});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_rv32i.md
# reg_file_rv32i

Integer register file for the single-cycle RV32I core. It holds x0–x31, with x0 hardwired to zero, and supplies the two ALU source operands (ALU op1/op2) in the same cycle they are addressed. It commits one writeback per clock from the ALU/load result path. It sits directly upstream of the ALU: rs1_data feeds op1, and rs2_data feeds op2 through the immediate mux.

## Interface
Parameters:
- n, 32, data width of each register and of all data ports
- a, 5, register address width (2^a registers)
- BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled; 0 = reads return the stored value only

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- reg_write  input  1  write enable for the writeback port
- rd_addr  input  a  destination register index
- rd_data  input  n  writeback data (ALU dout or load data)
- rs1_addr  input  a  source 1 index
- rs2_addr  input  a  source 2 index
- rs1_data  output  n  source 1 value, drives ALU op1
- rs2_data  output  n  source 2 value, drives ALU op2 / immediate mux
- dbg_addr  input  a  debug/testbench read index
- dbg_data  output  n  debug read value (no bypass)

## Operation
- Storage: 2^a − 1 physical n-bit registers, for x1..x31. x0 has no storage.
- Write: on a rising clk with rst=0, reg_write=1 and rd_addr≠0, regs[rd_addr] ← rd_data.
  - A write to x0 is silently dropped.
  - With reg_write=0, state is unchanged.
- Reset: on a rising clk with rst=1, all registers are cleared to 0.
  - Any write presented in that cycle is discarded; reset wins.
- Read ports (rs1, rs2) are combinational, in priority order:
  1. rst=1 → 0.
  2. addr=0 → 0, even if reg_write=1 and rd_addr=0.
  3. BYPASS=1, reg_write=1 and rd_addr=addr → rd_data (forwarding).
  4. Otherwise → regs[addr].
- rs1 and rs2 are independent. Both may address the same register, and both may hit the bypass simultaneously.
- dbg_data: addr=0 → 0, else regs[dbg_addr].
  - Never bypassed and not gated by rst.
  - Reflects the post-reset zeros one edge after reset.

## Timing
- Read latency: 0 cycles (combinational from address, and from rd_data when bypass is active).
- Write latency: 1 edge. Without bypass, a value written at edge k is visible on the read ports after edge k. With BYPASS=1 it is visible in the same cycle it is presented.
- Reset values:
  - rs1_data = rs2_data = 0 while rst=1.
  - All registers, and hence dbg_data, read 0 from the first edge with rst=1 onward.
- Reset mid-operation: asserting rst in a cycle with a pending write cancels that write. Registers read 0 after that edge regardless of earlier contents.
- No combinational path from any input to any internal state other than through clk.
- Back-to-back writes to the same rd: the last edge wins. Bypass always forwards the current-cycle rd_data.

## Test plan
- Reset/x0: pulse rst 1 cycle, then read all 32 via dbg_addr → all 0x00000000. Write 0xDEADBEEF to x0 → rs1_addr=0 reads 0 in the same cycle and after the edge.
- Basic write/read: write x5=0xFFFFFFFF and x6=0x00000001 on consecutive edges, then rs1_addr=5, rs2_addr=6 → rs1_data=0xFFFFFFFF, rs2_data=0x00000001. ALU ADD (op_code 000) then yields dout=0, cry_out=1, zero_flag=1.
- Bypass: with x7=0x11111111 stored, present reg_write=1, rd_addr=7, rd_data=0x22222222, rs1_addr=rs2_addr=7 → both read 0x22222222 before the edge; dbg_data=0x11111111 until the edge, then 0x22222222. With BYPASS=0, both ports read 0x11111111 until the edge.
- Reset beats write: rst=1 together with reg_write=1, rd_addr=3, rd_data=0xABCD0000 → after the edge dbg_addr=3 reads 0. rs1_data=0 during rst.
- Write disable: reg_write=0, rd_addr=9, rd_data=0x5 for 3 cycles → x9 keeps its prior value (0 after reset).
- Full sweep: write x_i = i·0x01010101 for i=1..31, then read back on both ports → every value matches, and x0 reads 0.
